// File: rtl/dpram_fifo_ctrl.sv
// Valid/ready FIFO controller around a 16x8 dual-port RAM: port A writes, port B
// reads into a two-entry prefetch buffer so the consumer sees registered data.
module dpram_fifo_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W:0]   count,
  output logic              ram_we_a,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [DATA_W-1:0] ram_din_a,
  output logic              ram_we_b,
  output logic [ADDR_W-1:0] ram_addr_b,
  input  logic [DATA_W-1:0] ram_dout_b
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CW    = ADDR_W + 1;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CW-1:0]     ram_occ;
  logic              inflight;
  logic              out_valid;
  logic              skid_valid;
  logic [DATA_W-1:0] out_data;
  logic [DATA_W-1:0] skid_data;

  logic       push;
  logic       pop;
  logic       issue;
  logic [1:0] held;
  logic       out_free;

  // Handshakes and RAM pin drive; everything is forced idle while in reset.
  always_comb begin
    count      = rst ? '0 : CW'(ram_occ + CW'(inflight) + CW'(out_valid) + CW'(skid_valid));
    s_ready    = !rst && (count < CW'(DEPTH));
    m_valid    = out_valid && !rst;
    m_data     = out_data;
    push       = s_valid && s_ready;
    pop        = m_valid && m_ready;
    held       = 2'(inflight) + 2'(out_valid) + 2'(skid_valid);
    // Only prefetch when the word is guaranteed a slot in out/skid on landing.
    issue      = !rst && (ram_occ != '0) && ({1'b0, held} < (3'd2 + 3'(pop)));
    out_free   = !out_valid || (pop && !skid_valid);
    ram_we_a   = push;
    ram_addr_a = rst ? '0 : wr_ptr;
    ram_din_a  = s_data;
    ram_we_b   = 1'b0;
    ram_addr_b = rst ? '0 : rd_ptr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ram_occ    <= '0;
      inflight   <= 1'b0;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_data   <= '0;
      skid_data  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (issue) rd_ptr <= rd_ptr + ADDR_W'(1);
      inflight <= issue;
      ram_occ  <= ram_occ + CW'(push) - CW'(issue);

      // Output buffer: skid refills out on pop; a landing word takes the oldest free slot.
      if (pop && skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= inflight;
        if (inflight) skid_data <= ram_dout_b;
      end else if (out_free) begin
        out_valid <= inflight;
        if (inflight) out_data <= ram_dout_b;
      end else if (inflight) begin
        skid_valid <= 1'b1;
        skid_data  <= ram_dout_b;
      end
    end
  end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl: a RAM model plus a queue-based FIFO reference that
// predicts count, readiness, word order and first-word latency every cycle.
module tb_dpram_fifo_ctrl;

  logic       clk;
  logic       rst;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [4:0] count;
  logic       ram_we_a;
  logic [3:0] ram_addr_a;
  logic [7:0] ram_din_a;
  logic       ram_we_b;
  logic [3:0] ram_addr_b;
  logic [7:0] ram_dout_b;

  dpram_fifo_ctrl #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .count      (count),
    .ram_we_a   (ram_we_a),
    .ram_addr_a (ram_addr_a),
    .ram_din_a  (ram_din_a),
    .ram_we_b   (ram_we_b),
    .ram_addr_b (ram_addr_b),
    .ram_dout_b (ram_dout_b)
  );

  // 16x8 RAM with registered read; a same-address read returns the old word.
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
    ram_dout_b <= mem[ram_addr_b];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         c;
  } ent_t;

  ent_t q[$];
  int   cyc = 0;
  int   wr  = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic skid_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check against the reference at negedge, advance the reference.
  task automatic step(input logic sv, input logic [7:0] sd, input logic mr, input logic r);
    logic exp_sr;
    logic exp_mv;
    ent_t e;
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    rst     = r;
    @(negedge clk);
    exp_sr = !r && (q.size() < 16);
    exp_mv = 1'b0;
    if (!r && q.size() != 0) exp_mv = (cyc - q[0].c) >= 3;
    chk("s_ready", 32'(s_ready), 32'(exp_sr));
    chk("m_valid", 32'(m_valid), 32'(exp_mv));
    chk("count", 32'(count), r ? 32'd0 : 32'(q.size()));
    if (exp_mv) chk("m_data", 32'(m_data), 32'(q[0].d));
    chk("ram_we_a", 32'(ram_we_a), 32'(sv && exp_sr));
    chk("ram_addr_a", 32'(ram_addr_a), r ? 32'd0 : 32'(wr));
    chk("ram_we_b", 32'(ram_we_b), 32'd0);
    if (r) chk("ram_addr_b", 32'(ram_addr_b), 32'd0);
    if (sv && exp_sr) chk("ram_din_a", 32'(ram_din_a), 32'(sd));
    if (dut.skid_valid === 1'b1) skid_seen = 1'b1;
    if (r) begin
      q.delete();
      wr = 0;
    end else begin
      if (exp_mv && mr) void'(q.pop_front());
      if (sv && exp_sr) begin
        e.d = sd;
        e.c = cyc;
        q.push_back(e);
        wr = (wr + 1) % 16;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset and single-word latency
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1);
    chk("reset_m_data", 32'(m_data), 32'd0);
    step(1, 8'h0B, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 8'h00, 1, 0);

    // Fill to full with the consumer stalled, then try a 17th word, then drain
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
    chk("full_count", 32'(count), 32'd16);
    for (int i = 0; i < 3; i++) step(1, 8'hFF, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 8'h00, 1, 0);

    // Sustained streaming with both sides always ready
    for (int i = 0; i < 40; i++) step(1, 8'(8'h10 + i), 1, 0);
    for (int i = 0; i < 6; i++) step(0, 8'h00, 1, 0);

    // Consumer toggling every cycle forces use of the skid entry
    for (int i = 0; i < 40; i++) step(1, 8'($urandom), (i % 2) == 0, 0);
    for (int i = 0; i < 24; i++) step(0, 8'h00, 1, 0);
    chk("skid_seen", 32'(skid_seen), 32'd1);

    // Reset with five words held, then a fresh word after reset
    for (int i = 0; i < 5; i++) step(1, 8'(8'h50 + i), 0, 0);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 0);
    chk("pre_reset_count", 32'(count), 32'd5);
    step(0, 8'h00, 0, 1);
    step(1, 8'hA5, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(1)), 8'($urandom), $urandom_range(3) != 0, $urandom_range(63) == 0);
    for (int i = 0; i < 24; i++) step(0, 8'h00, 1, 0);
    chk("final_count", 32'(count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dpram_fifo_ctrl.md
# dpram_fifo_ctrl

Synchronous FIFO controller that turns the 16x8 `dual_port_ram` into a valid/ready stream buffer. Port A of the RAM is the write port and port B is the read port. Port B is prefetched into a two-entry output buffer, so the consumer sees registered data at full throughput. The block sits directly upstream of the RAM, driving its address and write-enable pins, and between a producer stream and a consumer stream.

## Interface
- `DATA_W`, default 8: word width; matches RAM `din`/`dout`.
- `ADDR_W`, default 4: RAM address width; `DEPTH` = 2^`ADDR_W` = 16.

Ports:
- `clk`, input, 1: single clock. Rising edge only.
- `rst`, input, 1: reset. Synchronous, active-high.
- `s_valid`, input, 1: producer has a word.
- `s_ready`, output, 1: FIFO accepts a word.
- `s_data`, input, `DATA_W`: producer word.
- `m_valid`, output, 1: output word available.
- `m_ready`, input, 1: consumer accepts a word.
- `m_data`, output, `DATA_W`: output word, registered.
- `count`, output, `ADDR_W`+1: total words held.
- `ram_we_a`, output, 1: to RAM `we_a`.
- `ram_addr_a`, output, `ADDR_W`: to RAM `addr_a`.
- `ram_din_a`, output, `DATA_W`: to RAM `din_a`.
- `ram_we_b`, output, 1: to RAM `we_b`. Constant 0.
- `ram_addr_b`, output, `ADDR_W`: to RAM `addr_b`.
- `ram_dout_b`, input, `DATA_W`: from RAM `dout_b`. Registered, 1-cycle read latency.

## Operation
- State:
  - `wr_ptr`, `rd_ptr`: `ADDR_W` bits each, wrap modulo `DEPTH`.
  - `ram_occ`: 0..16.
  - `inflight`: 1 bit.
  - Output buffer: `out_valid`/`out_data` plus `skid_valid`/`skid_data`.
- `count` = `ram_occ` + `inflight` + `out_valid` + `skid_valid`. It never exceeds `DEPTH`.
- Handshakes:
  - `push` = `s_valid & s_ready`, where `s_ready` = !`rst` & (`count` < `DEPTH`).
  - `pop` = `m_valid & m_ready`, where `m_valid` = `out_valid`.
- Write path:
  - `ram_we_a` = `push`, `ram_addr_a` = `wr_ptr`, `ram_din_a` = `s_data`, all combinational.
  - On `push`, `wr_ptr`+1.
- Read issue:
  - `issue` = (`ram_occ` > 0) & (`out_valid` + `skid_valid` + `inflight` − `pop` < 2) & !`rst`.
  - `ram_addr_b` = `rd_ptr` at all times.
  - On `issue`: `rd_ptr`+1 and `inflight` <= 1; otherwise `inflight` <= 0.
- `ram_occ` <= `ram_occ` + `push` − `issue`.
  - A word written at edge N is readable at issue in cycle N+1 or later.
  - Hence `rd_ptr` never equals `wr_ptr` during a simultaneous RAM write and read.
- Landing: when `inflight` = 1, `ram_dout_b` is captured at the edge ending that cycle.
  - If the output register is empty after this cycle's `pop`, the word goes to `out_data`.
  - Otherwise it goes to `skid_data`.
- Pop: on `pop`, `skid` moves to `out` if `skid_valid`, else `out_valid` clears unless a word lands.
  - Ordering is strictly FIFO: `out`, then `skid`, then in-flight, then RAM.
- Overflow and underflow are impossible by construction.
  - `s_valid` while `s_ready` = 0 is ignored.
  - `m_ready` while `m_valid` = 0 is ignored.

## Timing
- Reset, synchronous: all of the following are 0 on the first edge with `rst` = 1.
  - `wr_ptr`, `rd_ptr`, `ram_occ`, `inflight`, `out_valid`, `skid_valid`.
  - `out_data` and `skid_data` are cleared to 0.
- While `rst` = 1:
  - `s_ready` = 0, `ram_we_a` = 0, `m_valid` = 0, `count` = 0, `ram_addr_a` = 0, `ram_addr_b` = 0.
  - RAM contents are not cleared.
- Reset mid-operation discards all held words. `s_ready` = 1 in the first cycle after `rst` falls.
- First-word latency:
  - Push accepted in cycle 0, issue in cycle 1, land at the end of cycle 2.
  - `m_valid` = 1 in cycle 3.
- Throughput: 1 word/cycle sustained in both directions with `m_ready` held high.
- Simultaneous `push` and `pop` at `count` = `DEPTH`: push is refused, because `s_ready` depends on registered `count`.
- Simultaneous `push` and `pop` at intermediate fill: `count` is unchanged.
- Pointer wrap: 15 → 0. No special handling.

## Test plan
- Reset, then push 0x0B: `ram_we_a` = 1 with `addr` 0. `m_valid` rises exactly 3 cycles later with `m_data` = 0x0B. `count` goes 0 → 1 → 0 after pop.
- Fill with 0x00..0x0F while `m_ready` = 0:
  - `count` = 16 and `s_ready` = 0.
  - A 17th word 0xFF is not written (`ram_we_a` stays 0).
  - Drain: 0x00..0x0F arrive in order, then `m_valid` = 0.
- Streaming 40 words 0x10..0x37 with `s_valid` and `m_ready` held high:
  - After the first output, one word per cycle, in order.
  - Pointers wrap twice.
  - `count` stays ≤ 3 and never changes once steady.
- Toggle `m_ready` 1/0 every cycle during streaming: no word lost or duplicated, and `skid_valid` is observed set at least once.
- Assert `rst` for one cycle with `count` = 5:
  - Next cycle `count` = 0, `m_valid` = 0, `s_ready` = 1.
  - Push 0xA5: it emerges as the first word 3 cycles later.
- Throughout: `ram_we_b` = 0 always, and `ram_addr_a` ≠ `ram_addr_b` whenever `ram_we_a` and `issue` occur in the same cycle.
